pe_operand_feeder: RTL and testbench
====================================

# pe_operand_feeder

Edge-of-array operand source for the systolic PE grid. It buffers one operand vector (an A row or a B column) from the tile loader. On command it streams the vector into the first PE of its row or column, one word per cycle, using the PE's input-enable flow control. A programmable leading skew produces the diagonal wavefront the array needs, and an optional replay mode lets one vector be reused without reloading.

## Interface
- DATA_W, 16, operand word width (matches PE datapath)
- DEPTH, 16, max vector length (K) held in buffer
- CNT_W, 5, counter width; must satisfy 2^CNT_W > DEPTH
- SKEW, 0, idle cycles inserted before first word (= row/column index)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_last  in  1  marks final word of vector
- ld_ready  out  1  feeder accepts loader word
- start  in  1  single-cycle pulse, begin streaming loaded vector
- repeat_n  in  8  extra passes, sampled with start (only used with FEEDER_REPLAY_EN)
- out_data  out  DATA_W  operand to PE input_A/input_B
- out_en  out  1  out_data valid (drives PE input_en)
- out_ready  in  1  PE can accept (operand FIFO not full)
- out_last  out  1  final word of current pass
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse, vector fully delivered
- count  out  CNT_W  number of words currently loaded

## Operation
- FSM states: IDLE, LOADED, SKEW, STREAM.
- IDLE:
  - ld_ready=1.
  - Each ld_valid&&ld_ready writes buf[wr_ptr] and increments wr_ptr/count.
  - The handshake carrying ld_last, or the DEPTH-th word, moves the FSM to LOADED. A write at DEPTH without ld_last is treated as last.
- LOADED:
  - ld_ready=0.
  - start moves to SKEW, or to STREAM if SKEW==0. rd_ptr=0 and the pass counter is loaded.
- SKEW: out_en=0 for exactly SKEW cycles, then STREAM.
- STREAM:
  - out_en=1, out_data=buf[rd_ptr], out_last=(rd_ptr==count-1).
  - A transfer occurs when out_en&&out_ready; rd_ptr then increments.
  - After the last-word transfer with no passes remaining: pulse done, clear count/wr_ptr, return to IDLE.
- out_data, out_last and out_en stay stable while out_en&&!out_ready (no retraction).
- Ignored inputs:
  - start outside LOADED.
  - ld_valid outside IDLE (ld_ready=0).
  - start in IDLE when count==0.
- Reset values: state IDLE, ld_ready=1, out_en=0, out_data=0, out_last=0, busy=0, done=0, count=0, all pointers 0. Buffer contents are don't-care.
- Reset mid-load or mid-stream abandons the vector. No done pulse. Count returns to 0.

## Timing
- Load: one word per cycle. The ld_last handshake cycle is followed by LOADED on the next cycle.
- First out_en: SKEW+1 cycles after the start cycle. The SKEW=0 case gives out_en in the cycle after start.
- Throughput: 1 word/cycle when out_ready is held high. A vector of length K with no stalls occupies K cycles of out_en.
- done: asserted in the cycle after the final transfer, for exactly one cycle. busy deasserts in the same cycle.
- All outputs are registered, except ld_ready and busy, which are decoded from state.

## Configuration
- FEEDER_REPLAY_EN defined:
  - repeat_n is captured at start.
  - The vector streams repeat_n+1 times back to back: rd_ptr wraps to 0 with no bubble and no re-inserted skew.
  - out_last asserts on the final word of every pass. done asserts only after the final pass.
- FEEDER_REPLAY_EN undefined: repeat_n is ignored and exactly one pass is streamed.

## Structure
- Shared package pe_feeder_pkg holds:
  - the state enum (IDLE/LOADED/SKEW/STREAM);
  - default DATA_W;
  - the skew counter width constant.
- One sub-module, feeder_buf: a DEPTH x DATA_W register array with a synchronous write port and a combinational read port, addressed by wr_ptr/rd_ptr.

## Test plan
- Load 4 words (0x11,0x22,0x33,0x44, ld_last on 0x44), SKEW=0, start, out_ready=1 -> out_en for 4 consecutive cycles starting the cycle after start, out_last on 0x44, done one cycle later, count=0.
- SKEW=3, load 2 words, start -> out_en first high 4 cycles after start; data 0x11 then 0x22.
- Same vector with out_ready low for 2 cycles while 0x22 is presented -> 0x22 held stable, no loss or duplication, done delayed by 2 cycles.
- Load DEPTH=16 words without ld_last -> ld_ready drops after the 16th word, 17th ld_valid not accepted, stream delivers all 16.
- Assert rst mid-STREAM after 2 of 4 words -> outputs return to reset values immediately, no done pulse, new load accepted after release.
- With FEEDER_REPLAY_EN, repeat_n=2, 3-word vector -> 9 contiguous transfers, out_last on words 3/6/9, single done after the 9th.

Source files
------------

// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE operand feeder.
package pe_feeder_pkg;

  localparam int DATA_W_DEF = 16;
  // Width of the leading-skew down-counter; bounds SKEW to 2^SKEW_CW.
  localparam int SKEW_CW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADED,
    ST_SKEW,
    ST_STREAM
  } feeder_state_e;

endpackage

// File: rtl/pe_operand_feeder_buf.sv
// Operand vector storage: DEPTH x DATA_W registers, synchronous write, combinational read.
module feeder_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int          IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Addresses above DEPTH-1 are unreachable in normal use; guard them anyway.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i <= TOP)) mem_q[waddr_i[IW-1:0]] <= wdata_i;
  end

  assign rdata_o = (raddr_i <= TOP) ? mem_q[raddr_i[IW-1:0]] : '0;

endmodule

// File: rtl/pe_operand_feeder.sv
// Edge-of-array operand source: buffers one vector, streams it with skew into a PE.
// Optional FEEDER_REPLAY_EN: stream the vector repeat_n+1 times back to back.
module pe_operand_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5,
  parameter int SKEW   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              start_i,
  input  logic [7:0]        repeat_n_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_en_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  count_o
);

  feeder_state_e      state_q, state_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SKEW_CW-1:0] skew_q, skew_d;
  logic [7:0]         pass_q, pass_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_en_q, out_en_d;
  logic               out_last_q, out_last_d;
  logic               done_q, done_d;

  logic               buf_we;
  logic [CNT_W-1:0]   rd_addr;
  logic [CNT_W-1:0]   rd_nxt;
  logic [DATA_W-1:0]  rd_data;
  logic [7:0]         rep_start;
  logic               one_word;

`ifdef FEEDER_REPLAY_EN
  assign rep_start = repeat_n_i;
`else
  logic unused_repeat;
  assign unused_repeat = ^repeat_n_i;
  assign rep_start     = '0;
`endif

  feeder_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (CNT_W)
  ) u_buf (
    .clk_i  (clk_i),
    .we_i   (buf_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(ld_data_i),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // The registered output stage is loaded one word ahead: the read address is
  // the word that will be presented after the current edge.
  assign rd_nxt   = rd_ptr_q + CNT_W'(1);
  assign rd_addr  = (state_q == ST_STREAM && !out_last_q) ? rd_nxt : '0;
  assign one_word = (count_q == CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    skew_d     = skew_q;
    pass_d     = pass_q;
    out_data_d = out_data_q;
    out_en_d   = out_en_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    buf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_valid_i) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + CNT_W'(1);
          count_d  = count_q + CNT_W'(1);
          if (ld_last_i || (count_q == CNT_W'(DEPTH - 1))) state_d = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (start_i) begin
          rd_ptr_d = '0;
          pass_d   = rep_start;
          if (SKEW == 0) begin
            state_d    = ST_STREAM;
            out_en_d   = 1'b1;
            out_data_d = rd_data;
            out_last_d = one_word;
          end else begin
            state_d = ST_SKEW;
            skew_d  = SKEW_CW'(SKEW - 1);
          end
        end
      end
      ST_SKEW: begin
        if (skew_q == '0) begin
          state_d    = ST_STREAM;
          out_en_d   = 1'b1;
          out_data_d = rd_data;
          out_last_d = one_word;
        end else begin
          skew_d = skew_q - SKEW_CW'(1);
        end
      end
      ST_STREAM: begin
        // out_en is always high here, so a transfer is just out_ready.
        if (out_ready_i) begin
          if (!out_last_q) begin
            rd_ptr_d   = rd_nxt;
            out_data_d = rd_data;
            out_last_d = (rd_nxt == count_q - CNT_W'(1));
          end else if (pass_q != '0) begin
            pass_d     = pass_q - 8'd1;
            rd_ptr_d   = '0;
            out_data_d = rd_data;
            out_last_d = one_word;
          end else begin
            state_d    = ST_IDLE;
            out_en_d   = 1'b0;
            out_last_d = 1'b0;
            done_d     = 1'b1;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      skew_q     <= '0;
      pass_q     <= '0;
      out_data_q <= '0;
      out_en_q   <= 1'b0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      skew_q     <= skew_d;
      pass_q     <= pass_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

  assign ld_ready_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q != ST_IDLE);
  assign out_data_o = out_data_q;
  assign out_en_o   = out_en_q;
  assign out_last_o = out_last_q;
  assign done_o     = done_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench: instance 0 has SKEW=0, instance 1 has SKEW=3.
module tb_pe_operand_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid [2];
  logic [15:0] ld_data  [2];
  logic        ld_last  [2];
  logic        ld_ready [2];
  logic        start    [2];
  logic [7:0]  repeat_n [2];
  logic [15:0] out_data [2];
  logic        out_en   [2];
  logic        out_ready[2];
  logic        out_last [2];
  logic        busy     [2];
  logic        done     [2];
  logic [4:0]  count    [2];

  logic [15:0] vec [16];
  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_operand_feeder #(.DATA_W(16), .DEPTH(16), .CNT_W(5), .SKEW(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .ld_valid_i(ld_valid[0]), .ld_data_i(ld_data[0]), .ld_last_i(ld_last[0]), .ld_ready_o(ld_ready[0]),
    .start_i(start[0]), .repeat_n_i(repeat_n[0]),
    .out_data_o(out_data[0]), .out_en_o(out_en[0]), .out_ready_i(out_ready[0]), .out_last_o(out_last[0]),
    .busy_o(busy[0]), .done_o(done[0]), .count_o(count[0]));

  pe_operand_feeder #(.DATA_W(16), .DEPTH(16), .CNT_W(5), .SKEW(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .ld_valid_i(ld_valid[1]), .ld_data_i(ld_data[1]), .ld_last_i(ld_last[1]), .ld_ready_o(ld_ready[1]),
    .start_i(start[1]), .repeat_n_i(repeat_n[1]),
    .out_data_o(out_data[1]), .out_en_o(out_en[1]), .out_ready_i(out_ready[1]), .out_last_o(out_last[1]),
    .busy_o(busy[1]), .done_o(done[1]), .count_o(count[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      ld_valid[k] = 1'b1;
      ld_data[k]  = vec[i];
      ld_last[k]  = use_last && (i == n - 1);
      tick();
    end
    ld_valid[k] = 1'b0;
    ld_last[k]  = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  // Expects word 0 to be presented now and out_ready held high throughout.
  task automatic stream_chk(input int k, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s en[%0d]", tag, i), 32'(out_en[k]), 32'd1);
      chk($sformatf("%s data[%0d]", tag, i), 32'(out_data[k]), 32'(vec[i]));
      chk($sformatf("%s last[%0d]", tag, i), 32'(out_last[k]), 32'(i == n - 1));
      chk($sformatf("%s nodone[%0d]", tag, i), 32'(done[k]), 32'd0);
      tick();
    end
    chk({tag, " done"}, 32'(done[k]), 32'd1);
    chk({tag, " busy_off"}, 32'(busy[k]), 32'd0);
    chk({tag, " en_off"}, 32'(out_en[k]), 32'd0);
    chk({tag, " count_clr"}, 32'(count[k]), 32'd0);
    tick();
    chk({tag, " done_1cyc"}, 32'(done[k]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ld_valid[k] = 1'b0; ld_data[k] = '0; ld_last[k] = 1'b0;
      start[k] = 1'b0; repeat_n[k] = '0; out_ready[k] = 1'b1;
    end
    tick(); tick();
    chk("rst ld_ready", 32'(ld_ready[0]), 32'd1);
    chk("rst out_en", 32'(out_en[0]), 32'd0);
    chk("rst out_data", 32'(out_data[0]), 32'd0);
    chk("rst out_last", 32'(out_last[0]), 32'd0);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst done", 32'(done[0]), 32'd0);
    chk("rst count", 32'(count[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // start with nothing loaded is ignored
    pulse_start(0);
    chk("empty start busy", 32'(busy[0]), 32'd0);
    chk("empty start en", 32'(out_en[0]), 32'd0);

    // 4-word vector, SKEW=0
    vec[0] = 16'h11; vec[1] = 16'h22; vec[2] = 16'h33; vec[3] = 16'h44;
    load(0, 4, 1'b1);
    chk("t1 count", 32'(count[0]), 32'd4);
    chk("t1 ld_ready", 32'(ld_ready[0]), 32'd0);
    chk("t1 busy", 32'(busy[0]), 32'd1);
    chk("t1 en_before_start", 32'(out_en[0]), 32'd0);
    pulse_start(0);
    stream_chk(0, 4, "t1");

    // 2-word vector, SKEW=3
    load(1, 2, 1'b1);
    pulse_start(1);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t2 skew_en c%0d", c), 32'(out_en[1]), 32'd0);
      chk($sformatf("t2 skew_busy c%0d", c), 32'(busy[1]), 32'd1);
      tick();
    end
    stream_chk(1, 2, "t2");

    // Same vector, two stall cycles while 0x22 is presented
    load(1, 2, 1'b1);
    pulse_start(1);
    tick(); tick(); tick();
    chk("t3 w0", 32'(out_data[1]), 32'h11);
    tick();
    chk("t3 w1", 32'(out_data[1]), 32'h22);
    out_ready[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk($sformatf("t3 hold_data s%0d", s), 32'(out_data[1]), 32'h22);
      chk($sformatf("t3 hold_en s%0d", s), 32'(out_en[1]), 32'd1);
      chk($sformatf("t3 hold_last s%0d", s), 32'(out_last[1]), 32'd1);
      chk($sformatf("t3 hold_nodone s%0d", s), 32'(done[1]), 32'd0);
    end
    out_ready[1] = 1'b1;
    tick();
    chk("t3 done", 32'(done[1]), 32'd1);
    chk("t3 en_off", 32'(out_en[1]), 32'd0);
    tick();
    chk("t3 done_1cyc", 32'(done[1]), 32'd0);

    // Full-depth load without ld_last
    for (int i = 0; i < 16; i++) vec[i] = 16'h100 + 16'(i);
    load(0, 15, 1'b0);
    chk("t4 ready_before_16th", 32'(ld_ready[0]), 32'd1);
    ld_valid[0] = 1'b1; ld_data[0] = vec[15];
    tick();
    chk("t4 ready_after_16th", 32'(ld_ready[0]), 32'd0);
    chk("t4 count16", 32'(count[0]), 32'd16);
    ld_data[0] = 16'hDEAD;
    tick();
    ld_valid[0] = 1'b0;
    chk("t4 count_after_17th", 32'(count[0]), 32'd16);
    pulse_start(0);
    stream_chk(0, 16, "t4");

    // Reset after two of four words have transferred
    vec[0] = 16'h11; vec[1] = 16'h22; vec[2] = 16'h33; vec[3] = 16'h44;
    load(0, 4, 1'b1);
    pulse_start(0);
    tick(); tick();
    chk("t5 pre_rst data", 32'(out_data[0]), 32'h33);
    rst_n = 1'b0;
    #1;
    chk("t5 rst en", 32'(out_en[0]), 32'd0);
    chk("t5 rst data", 32'(out_data[0]), 32'd0);
    chk("t5 rst last", 32'(out_last[0]), 32'd0);
    chk("t5 rst busy", 32'(busy[0]), 32'd0);
    chk("t5 rst done", 32'(done[0]), 32'd0);
    chk("t5 rst count", 32'(count[0]), 32'd0);
    chk("t5 rst ld_ready", 32'(ld_ready[0]), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5 post_rst done", 32'(done[0]), 32'd0);
    vec[0] = 16'hA1; vec[1] = 16'hA2;
    load(0, 2, 1'b1);
    chk("t5 reload count", 32'(count[0]), 32'd2);
    pulse_start(0);
    stream_chk(0, 2, "t5");

    // Replay request: repeat_n=2 on a 3-word vector
    vec[0] = 16'hB1; vec[1] = 16'hB2; vec[2] = 16'hB3;
    load(0, 3, 1'b1);
    repeat_n[0] = 8'd2;
    pulse_start(0);
    repeat_n[0] = 8'd0;
`ifdef FEEDER_REPLAY_EN
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t6 en[%0d]", i), 32'(out_en[0]), 32'd1);
      chk($sformatf("t6 data[%0d]", i), 32'(out_data[0]), 32'(vec[i % 3]));
      chk($sformatf("t6 last[%0d]", i), 32'(out_last[0]), 32'((i % 3) == 2));
      chk($sformatf("t6 nodone[%0d]", i), 32'(done[0]), 32'd0);
      tick();
    end
    chk("t6 done", 32'(done[0]), 32'd1);
    chk("t6 en_off", 32'(out_en[0]), 32'd0);
    tick();
    chk("t6 done_1cyc", 32'(done[0]), 32'd0);
`else
    stream_chk(0, 3, "t6");
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
